fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the byte address of the first fetch after reset.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: imem_req  out  1  fetch request to instruction memory.
REQ-006 Port: imem_addr  out  16  byte address of the request; valid while imem_req=1.
REQ-007 Port: imem_gnt  in  1  request accepted this cycle; only meaningful when imem_req=1.
REQ-008 Port: imem_rvalid  in  1  read data valid; arrives 1 or more cycles after the grant.
REQ-009 Port: imem_rdata  in  16  instruction word returned with imem_rvalid.
REQ-010 Port: inst_valid  out  1  instruction available to decode.
REQ-011 Port: inst_ready  in  1  decode consumes the head instruction this cycle.
REQ-012 Port: inst  out  16  head instruction word.
REQ-013 Port: inst_pc  out  16  byte address of the head instruction.
REQ-014 Port: opcode  out  5  inst[15:11], the control-decode opcode field.
REQ-015 Port: redirect  in  1  branch/jump taken; flush and refetch from redirect_pc.
REQ-016 Port: redirect_pc  in  16  target byte address; bit 0 ignored and treated as 0.

Function
REQ-017 SHALL hold a 2-entry prefetch FIFO, each entry {inst[15:0], pc[15:0]}; count ranges 0..2.
REQ-018 SHALL implement FSM states FETCH, WAIT and DROP, with at most one memory request outstanding.
REQ-019 In FETCH: imem_req=1 iff count<2 and redirect=0; imem_addr=fetch_pc.
REQ-020 In FETCH with imem_req=1 and imem_gnt=1: latch req_pc=fetch_pc, fetch_pc+=2 (16-bit wrap, 16'hFFFE -> 16'h0000), go to WAIT.
REQ-021 In WAIT and DROP: imem_req=0.
REQ-022 In WAIT with imem_rvalid=1: push {imem_rdata, req_pc}, go to FETCH. Space is guaranteed by REQ-019.
REQ-023 In DROP with imem_rvalid=1: discard the data and go to FETCH.
REQ-024 inst_valid=(count!=0); inst, inst_pc and opcode SHALL show the head entry; when count=0 these values are don't-care.
REQ-025 Pop occurs when inst_valid=1 and inst_ready=1. Push and pop in the same cycle SHALL leave count unchanged, and the order SHALL be preserved.
REQ-026 On redirect=1, in any state, in the same cycle:
  - clear the FIFO (count=0); any pop or push that cycle is ignored;
  - set fetch_pc={redirect_pc[15:1],1'b0}.
REQ-027 State after a redirect:
  - redirect in WAIT without rvalid -> DROP;
  - redirect in WAIT with rvalid -> FETCH (data discarded);
  - redirect in DROP -> DROP, unless rvalid is also high -> FETCH;
  - redirect in FETCH -> FETCH, because REQ-019 blocks the request that cycle.
REQ-028 The first inst_valid after a redirect SHALL carry inst_pc equal to the redirect target.
REQ-029 imem_gnt SHALL be ignored when imem_req=0, and imem_rvalid SHALL be ignored in FETCH.
REQ-030 Fetch latency: an instruction becomes visible on inst_valid the cycle after its imem_rvalid.
REQ-031 Peak throughput is one instruction per 2 cycles with single-cycle grant and response.

Reset
REQ-032 On a clock edge with reset=1:
  - state=FETCH, count=0, fetch_pc=RESET_PC;
  - all other inputs are ignored that cycle.
REQ-033 Output values after the first reset edge: imem_req=0 while reset is held, inst_valid=0, imem_addr=RESET_PC.
REQ-034 Reset while in WAIT SHALL abandon the outstanding request. The memory's late rvalid then arrives in FETCH and is ignored per REQ-029.
REQ-035 The first request after reset release SHALL have imem_addr=RESET_PC.

Verification
REQ-036 Reset, then gnt=1 and rvalid 1 cycle later, inst_ready=0, with mem[0]=16'hF812, mem[2]=16'h4005:
  - two entries are held: inst_pc 0000 (inst F812, opcode 11111), then 0002 (inst 4005);
  - imem_req stays 0 while count=2.
REQ-037 FIFO full, then inst_ready=1 on the same cycle a new response returns:
  - count stays 2 and entries pop in order;
  - fetch_pc advances 0004 -> 0006.
REQ-038 Request granted at 0004 with response delayed 3 cycles; redirect to 16'h0101 in the cycle after the grant:
  - the FSM goes to DROP and the data for 0004 is discarded;
  - the next request has imem_addr=0100, and the first inst_pc is 0100.
REQ-039 Redirect in the same cycle as imem_rvalid and inst_ready=1:
  - count becomes 0 and the returned data is dropped;
  - the next request uses the redirect target.
REQ-040 Fetch from 16'hFFFE: the following request address wraps to 16'h0000.
REQ-041 Assert reset during WAIT, then deliver a stale rvalid 2 cycles after reset release:
  - no instruction is pushed from the stale response;
  - the first inst_pc equals RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request feeding a
// two-entry prefetch FIFO, with flush/refetch on a taken branch or jump.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [4:0]  opcode,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] fetch_pc;
    logic [15:0] req_pc;
    logic [15:0] redirect_target;
    logic [15:0] buf_inst [2];
    logic [15:0] buf_pc   [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        grant;
    logic        push;
    logic        pop;

    assign redirect_target = redirect_pc & 16'hFFFE;

    assign inst_valid = (count != 2'd0);
    assign inst       = buf_inst[rd_ptr];
    assign inst_pc    = buf_pc[rd_ptr];
    assign opcode     = inst[15:11];
    assign imem_addr  = fetch_pc;
    assign pop        = inst_valid && inst_ready && !redirect;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        grant     = 1'b0;
        push      = 1'b0;
        unique case (state)
            FETCH: begin
                imem_req = !reset && (count != 2'd2) && !redirect;
                grant    = imem_req && imem_gnt;
                if (grant)
                    state_nxt = WAIT;
            end
            WAIT: begin
                // A redirect racing the response discards it but still
                // retires the request, so no DROP is needed.
                if (imem_rvalid) begin
                    push      = !redirect;
                    state_nxt = FETCH;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid)
                    state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
                fetch_pc <= redirect_target;
            end else begin
                if (grant) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 16'd2;
                end
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model of the fetch queue and memory.
module tb_fetch_unit;

    localparam logic [15:0] RPC = 16'h0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [4:0]  opcode;
    logic        redirect;
    logic [15:0] redirect_pc;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .opcode     (opcode),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // memory model
    int          pend = -1;
    logic [15:0] maddr = 16'h0;
    bit          gnt_en = 1'b1;
    bit          rand_gnt = 1'b0;
    int          lat_cfg = 1;

    // reference model
    typedef struct packed {
        logic [15:0] i;
        logic [15:0] p;
    } ent_t;
    ent_t        q[$];
    bit          busy = 1'b0;
    bit          drop = 1'b0;
    logic [15:0] m_fpc = RPC;
    logic [15:0] m_rpc = RPC;

    bit          s_req;
    bit          s_gnt;
    bit          s_rv;
    logic [15:0] s_addr;
    logic [15:0] s_rdata;

    function automatic logic [15:0] memf(input logic [15:0] a);
        logic [15:0] t;
        if (a == 16'h0000) return 16'hF812;
        if (a == 16'h0002) return 16'h4005;
        t = a * 16'h9E37;
        return t ^ 16'h3C3C;
    endfunction

    task automatic setup(input bit rst, input bit rdr,
                         input logic [15:0] rpc, input bit rdy);
        reset       = rst;
        redirect    = rdr;
        redirect_pc = rpc;
        inst_ready  = rdy;
        imem_rvalid = (pend == 0);
        imem_rdata  = (pend == 0) ? memf(maddr) : 16'($urandom);
        #1;
        if (rand_gnt)
            imem_gnt = gnt_en && ($urandom_range(0, 1) == 1);
        else
            imem_gnt = gnt_en && imem_req;
        #1;
        s_req   = imem_req;
        s_gnt   = imem_gnt;
        s_rv    = imem_rvalid;
        s_addr  = imem_addr;
        s_rdata = imem_rdata;
    endtask

    task automatic finish_cycle();
        if (reset) begin
            q.delete();
            busy  = 1'b0;
            drop  = 1'b0;
            m_fpc = RPC;
        end else if (redirect) begin
            q.delete();
            m_fpc = redirect_pc & 16'hFFFE;
            if (busy && s_rv) begin
                busy = 1'b0;
                drop = 1'b0;
            end else if (busy) begin
                drop = 1'b1;
            end
        end else begin
            if (q.size() != 0 && inst_ready)
                q.delete(0);
            if (busy && s_rv) begin
                if (!drop)
                    q.push_back('{i: s_rdata, p: m_rpc});
                busy = 1'b0;
                drop = 1'b0;
            end
            if (s_req && s_gnt) begin
                busy  = 1'b1;
                drop  = 1'b0;
                m_rpc = m_fpc;
                m_fpc = m_fpc + 16'd2;
            end
        end
        if (pend == 0)
            pend = -1;
        else if (pend > 0)
            pend = pend - 1;
        if (s_req && s_gnt) begin
            pend  = (lat_cfg > 0) ? lat_cfg - 1 : $urandom_range(0, 2);
            maddr = s_addr;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        pend = -1;
        setup(1'b1, 1'b0, 16'h0, 1'b0);
        finish_cycle();
        setup(1'b1, 1'b0, 16'h0, 1'b0);
        finish_cycle();
    endtask

    task automatic test_reset();
        gnt_en = 1'b1;
        setup(1'b1, 1'b0, 16'h0, 1'b0);
        finish_cycle();
        setup(1'b1, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req);
        else n_pass++;
        n_total++;
        if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid);
        else n_pass++;
        n_total++;
        if (imem_addr !== RPC) $display("FAIL reset_addr: got %h want %h", imem_addr, RPC);
        else n_pass++;
        finish_cycle();
        gnt_en = 1'b0;
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== RPC)
            $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h",
                     imem_req, imem_addr, RPC);
        else n_pass++;
        finish_cycle();
        gnt_en = 1'b1;
    endtask

    task automatic test_fill();
        lat_cfg = 1;
        for (int c = 0; c < 4; c++) begin
            setup(1'b0, 1'b0, 16'h0, 1'b0);
            finish_cycle();
        end
        for (int c = 0; c < 2; c++) begin
            setup(1'b0, 1'b0, 16'h0, 1'b0);
            n_total++;
            if (inst_valid !== 1'b1 || inst_pc !== 16'h0000 || inst !== 16'hF812)
                $display("FAIL fill_head: got v=%b pc=%h inst=%h want 1 0000 f812",
                         inst_valid, inst_pc, inst);
            else n_pass++;
            n_total++;
            if (opcode !== 5'b11111) $display("FAIL fill_opcode: got %b want 11111", opcode);
            else n_pass++;
            n_total++;
            if (imem_req !== 1'b0) $display("FAIL full_no_req: got %b want 0", imem_req);
            else n_pass++;
            finish_cycle();
        end
    endtask

    task automatic test_pop_push();
        setup(1'b0, 1'b0, 16'h0, 1'b1);
        n_total++;
        if (inst_pc !== 16'h0000) $display("FAIL pop_first: got %h want 0000", inst_pc);
        else n_pass++;
        finish_cycle();
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (inst_pc !== 16'h0002 || inst !== 16'h4005)
            $display("FAIL pop_second: got pc=%h inst=%h want 0002 4005", inst_pc, inst);
        else n_pass++;
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0004)
            $display("FAIL req_0004: got req=%b addr=%h want 1 0004", imem_req, imem_addr);
        else n_pass++;
        finish_cycle();
        setup(1'b0, 1'b0, 16'h0, 1'b1);
        n_total++;
        if (imem_rvalid !== 1'b1 || inst_pc !== 16'h0002)
            $display("FAIL pushpop_cycle: got rv=%b pc=%h want 1 0002", imem_rvalid, inst_pc);
        else n_pass++;
        finish_cycle();
        gnt_en = 1'b0;
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0004 || inst !== memf(16'h0004))
            $display("FAIL pushpop_head: got v=%b pc=%h inst=%h want 1 0004 %h",
                     inst_valid, inst_pc, inst, memf(16'h0004));
        else n_pass++;
        n_total++;
        if (imem_addr !== 16'h0006) $display("FAIL fetch_pc_0006: got %h want 0006", imem_addr);
        else n_pass++;
        finish_cycle();
        gnt_en = 1'b1;
    endtask

    task automatic test_redirect_drop();
        bit seen;
        apply_reset();
        setup(1'b0, 1'b1, 16'h0004, 1'b0);
        finish_cycle();
        lat_cfg = 3;
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0004)
            $display("FAIL drop_req4: got req=%b addr=%h want 1 0004", imem_req, imem_addr);
        else n_pass++;
        finish_cycle();
        lat_cfg = 1;
        setup(1'b0, 1'b1, 16'h0101, 1'b1);
        finish_cycle();
        for (int c = 0; c < 2; c++) begin
            setup(1'b0, 1'b0, 16'h0, 1'b1);
            n_total++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0)
                $display("FAIL drop_idle: got req=%b v=%b want 0 0", imem_req, inst_valid);
            else n_pass++;
            finish_cycle();
        end
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || inst_valid !== 1'b0)
            $display("FAIL drop_refetch: got req=%b addr=%h v=%b want 1 0100 0",
                     imem_req, imem_addr, inst_valid);
        else n_pass++;
        finish_cycle();
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            setup(1'b0, 1'b0, 16'h0, 1'b0);
            if (inst_valid === 1'b1) begin
                seen = 1'b1;
                n_total++;
                if (inst_pc !== 16'h0100 || inst !== memf(16'h0100))
                    $display("FAIL drop_first_pc: got pc=%h inst=%h want 0100 %h",
                             inst_pc, inst, memf(16'h0100));
                else n_pass++;
            end
            finish_cycle();
        end
        if (!seen) begin
            n_total++;
            $display("FAIL drop_timeout: got no inst_valid want one within 8 cycles");
        end
    endtask

    task automatic test_redirect_rvalid();
        apply_reset();
        lat_cfg = 1;
        for (int c = 0; c < 3; c++) begin
            setup(1'b0, 1'b0, 16'h0, 1'b0);
            finish_cycle();
        end
        setup(1'b0, 1'b1, 16'h0201, 1'b1);
        n_total++;
        if (imem_rvalid !== 1'b1 || inst_valid !== 1'b1)
            $display("FAIL rdr_rv_setup: got rv=%b v=%b want 1 1", imem_rvalid, inst_valid);
        else n_pass++;
        finish_cycle();
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (inst_valid !== 1'b0) $display("FAIL rdr_rv_flush: got %b want 0", inst_valid);
        else n_pass++;
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0200)
            $display("FAIL rdr_rv_req: got req=%b addr=%h want 1 0200", imem_req, imem_addr);
        else n_pass++;
        finish_cycle();
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        finish_cycle();
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0200)
            $display("FAIL rdr_rv_first: got v=%b pc=%h want 1 0200", inst_valid, inst_pc);
        else n_pass++;
        finish_cycle();
    endtask

    task automatic test_wrap();
        apply_reset();
        lat_cfg = 1;
        setup(1'b0, 1'b1, 16'hFFFF, 1'b0);
        finish_cycle();
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE)
            $display("FAIL wrap_req: got req=%b addr=%h want 1 fffe", imem_req, imem_addr);
        else n_pass++;
        finish_cycle();
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        finish_cycle();
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
            $display("FAIL wrap_next: got req=%b addr=%h want 1 0000", imem_req, imem_addr);
        else n_pass++;
        n_total++;
        if (inst_pc !== 16'hFFFE || inst !== memf(16'hFFFE))
            $display("FAIL wrap_head: got pc=%h inst=%h want fffe %h",
                     inst_pc, inst, memf(16'hFFFE));
        else n_pass++;
        finish_cycle();
    endtask

    task automatic test_reset_wait();
        bit seen;
        apply_reset();
        setup(1'b0, 1'b1, 16'h0040, 1'b0);
        finish_cycle();
        lat_cfg = 3;
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        finish_cycle();
        setup(1'b1, 1'b0, 16'h0, 1'b0);
        finish_cycle();
        gnt_en = 1'b0;
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        finish_cycle();
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (imem_rvalid !== 1'b1) $display("FAIL stale_rv_driven: got %b want 1", imem_rvalid);
        else n_pass++;
        finish_cycle();
        lat_cfg = 1;
        gnt_en  = 1'b1;
        setup(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if (inst_valid !== 1'b0) $display("FAIL stale_pushed: got v=%b want 0", inst_valid);
        else n_pass++;
        finish_cycle();
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            setup(1'b0, 1'b0, 16'h0, 1'b0);
            if (inst_valid === 1'b1) begin
                seen = 1'b1;
                n_total++;
                if (inst_pc !== RPC || inst !== memf(RPC))
                    $display("FAIL stale_first: got pc=%h inst=%h want %h %h",
                             inst_pc, inst, RPC, memf(RPC));
                else n_pass++;
            end
            finish_cycle();
        end
        if (!seen) begin
            n_total++;
            $display("FAIL stale_timeout: got no inst_valid want one within 8 cycles");
        end
    endtask

    task automatic test_random();
        bit          rdr;
        logic [15:0] rpc;
        bit          exp_req;
        apply_reset();
        rand_gnt = 1'b1;
        lat_cfg  = 0;
        for (int c = 0; c < 3000; c++) begin
            rdr = ($urandom_range(0, 15) == 0);
            rpc = 16'($urandom);
            setup(1'b0, rdr, rpc, $urandom_range(0, 2) != 0);
            exp_req = !busy && (q.size() < 2) && !rdr;
            n_total++;
            if (inst_valid !== (q.size() != 0))
                $display("FAIL rnd_valid c=%0d: got %b want %b", c, inst_valid, q.size() != 0);
            else n_pass++;
            if (q.size() != 0) begin
                n_total++;
                if (inst_pc !== q[0].p || inst !== q[0].i || opcode !== q[0].i[15:11])
                    $display("FAIL rnd_head c=%0d: got pc=%h inst=%h op=%b want %h %h %b",
                             c, inst_pc, inst, opcode, q[0].p, q[0].i, q[0].i[15:11]);
                else n_pass++;
            end
            n_total++;
            if (imem_req !== exp_req)
                $display("FAIL rnd_req c=%0d: got %b want %b", c, imem_req, exp_req);
            else n_pass++;
            if (exp_req) begin
                n_total++;
                if (imem_addr !== m_fpc)
                    $display("FAIL rnd_addr c=%0d: got %h want %h", c, imem_addr, m_fpc);
                else n_pass++;
            end
            finish_cycle();
        end
        rand_gnt = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        inst_ready  = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_pop_push();
        test_redirect_drop();
        test_redirect_rvalid();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
